pc_seq_unit: RTL and testbench

- Parametrised program counter for the instruction fetch path. Successor to the 4-bit fixed PC.
- Supports:
  - configurable address width and reset vector;
  - stall;
  - absolute jump;
  - PC-relative signed branch;
  - call/return through a hardware return-address stack (RAS).
- Drives the instruction-memory address every cycle. Sits between the control decoder (jmp/ban/call/ret strobes) and instruction ROM.

---
 rtl/pc_seq_unit.sv | 65 ++++++
 tb/tb_pc_seq_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: parametrised program counter with stall, jump, signed branch and call/return stack.
// Define PC_RAS_EN to build the return-address stack; without it, call acts as jmp and ret is ignored.
module pc_seq_unit #(
  parameter int ADDR_W = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              pc_reset,
  input  logic              stop,
  input  logic              jmp,
  input  logic              ban,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] addrJmp,
  output logic [ADDR_W-1:0] addr,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_err
);
  logic [ADDR_W-1:0] addr_inc;
  assign addr_inc = addr + ADDR_W'(1);
`ifdef PC_RAS_EN
  localparam int SP_W = $clog2(RAS_DEPTH) + 1;
  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [SP_W-1:0]   sp;
  logic [SP_W-2:0]   top;
  logic              push;
  assign top       = sp[SP_W-2:0] - 1'b1;
  assign ras_empty = sp == '0;
  assign ras_full  = sp == SP_W'(RAS_DEPTH);
  assign push      = !pc_reset && !stop && !ret && call && !ras_full;
  always_ff @(posedge clk)
    if (push) ras[sp[SP_W-2:0]] <= addr_inc;
  always_ff @(posedge clk) begin
    if (pc_reset) begin
      addr    <= RESET_ADDR;
      sp      <= '0;
      ras_err <= 1'b0;
    end else if (!stop) begin
      if (ret) begin
        addr    <= ras_empty ? addr_inc : ras[top];
        sp      <= ras_empty ? sp : sp - 1'b1;
        ras_err <= ras_err | ras_empty;
      end else if (call) begin
        addr    <= addrJmp;
        sp      <= ras_full ? sp : sp + 1'b1;
        ras_err <= ras_err | ras_full;
      end else begin
        addr <= jmp ? addrJmp : ban ? addr + addrJmp : addr_inc;
      end
    end
  end
`else
  logic unused_ras;
  assign unused_ras = ret ^ (RAS_DEPTH == 0);
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
  assign ras_err    = 1'b0;
  always_ff @(posedge clk) begin
    if (pc_reset) addr <= RESET_ADDR;
    else if (!stop) addr <= (call || jmp) ? addrJmp : ban ? addr + addrJmp : addr_inc;
  end
`endif
endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed and random checks of pc_seq_unit against a queue-based reference model.
module tb_pc_seq_unit;
  localparam int DEPTH = 4;
`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic pc_reset, stop, jmp, ban, call, ret;
  logic [3:0] addrJmp, addr;
  logic ras_empty, ras_full, ras_err;
  int checks = 0;
  int errors = 0;
  int m_addr;
  int stk[$];
  bit m_err;

  pc_seq_unit #(.ADDR_W(4), .RESET_ADDR(4'd0), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .pc_reset(pc_reset), .stop(stop), .jmp(jmp), .ban(ban), .call(call), .ret(ret),
    .addrJmp(addrJmp), .addr(addr), .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] expv();
    logic [3:0] a;
    a = 4'(m_addr);
    return {a, RAS_EN ? (stk.size() == 0) : 1'b1, RAS_EN ? (stk.size() == DEPTH) : 1'b0, RAS_EN ? m_err : 1'b0};
  endfunction

  // Drives one cycle of stimulus and advances the reference model by the same edge.
  task automatic apply(input bit r, s, t, c, j, b, input int a);
    int off;
    pc_reset = r; stop = s; ret = t; call = c; jmp = j; ban = b; addrJmp = 4'(a);
    @(posedge clk); #1;
    off = (a >= 8) ? a - 16 : a;
    if (r) begin
      m_addr = 0; stk.delete(); m_err = 0;
    end else if (s) begin
    end else if (RAS_EN && t) begin
      if (stk.size() == 0) begin m_addr = (m_addr + 1) % 16; m_err = 1; end
      else m_addr = stk.pop_back();
    end else if (c) begin
      if (RAS_EN) begin
        if (stk.size() == DEPTH) m_err = 1;
        else stk.push_back((m_addr + 1) % 16);
      end
      m_addr = a;
    end else if (j) m_addr = a;
    else if (b) m_addr = (m_addr + off + 16) % 16;
    else m_addr = (m_addr + 1) % 16;
    pc_reset = 0; stop = 0; ret = 0; call = 0; jmp = 0; ban = 0;
  endtask

  task automatic test_reset();
    apply(1, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({addr, ras_empty, ras_full, ras_err} !== 7'b0000_100) begin
      errors++; $display("FAIL reset got %b want %b", {addr, ras_empty, ras_full, ras_err}, 7'b0000_100);
    end
  endtask

  task automatic test_increment();
    for (int i = 1; i <= 17; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (addr !== 4'(i % 16) || ras_empty !== 1'b1) begin
        errors++; $display("FAIL increment step %0d got addr %0d empty %b want %0d 1", i, addr, ras_empty, i % 16);
      end
    end
  endtask

  task automatic test_stall_jump();
    apply(0, 0, 0, 0, 1, 0, 5);
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 0, 0, 1, 1, 9);
      checks++;
      if (addr !== 4'd5) begin errors++; $display("FAIL stall got %0d want 5", addr); end
    end
    apply(0, 0, 0, 0, 1, 0, 12);
    checks++;
    if (addr !== 4'd12) begin errors++; $display("FAIL jmp got %0d want 12", addr); end
    apply(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (addr !== 4'd13) begin errors++; $display("FAIL jmp_next got %0d want 13", addr); end
  endtask

  task automatic test_branch();
    apply(0, 0, 0, 0, 1, 0, 3);
    apply(0, 0, 0, 0, 0, 1, 14);
    checks++;
    if (addr !== 4'd1) begin errors++; $display("FAIL ban_neg got %0d want 1", addr); end
    apply(0, 0, 0, 0, 1, 0, 14);
    apply(0, 0, 0, 0, 0, 1, 3);
    checks++;
    if (addr !== 4'd1) begin errors++; $display("FAIL ban_wrap got %0d want 1", addr); end
    apply(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (addr !== 4'd1) begin errors++; $display("FAIL ban_self got %0d want 1", addr); end
    apply(0, 0, 0, 0, 1, 1, 9);
    checks++;
    if (addr !== 4'd9) begin errors++; $display("FAIL jmp_over_ban got %0d want 9", addr); end
  endtask

  task automatic test_call_ret();
    int seq[4][2] = '{'{1, 8}, '{1, 12}, '{0, 0}, '{0, 0}};
    apply(1, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 1, 0, 2);
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, !seq[i][0], seq[i][0], 0, 0, seq[i][1]);
      checks++;
      if ({addr, ras_empty, ras_full, ras_err} !== expv()) begin
        errors++; $display("FAIL call_ret step %0d got %b want %b", i, {addr, ras_empty, ras_full, ras_err}, expv());
      end
    end
  endtask

  task automatic test_ras_errors();
    apply(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 0, 1, 0, 0, 3 * i + 1);
      checks++;
      if ({addr, ras_empty, ras_full, ras_err} !== expv()) begin
        errors++; $display("FAIL call_full step %0d got %b want %b", i, {addr, ras_empty, ras_full, ras_err}, expv());
      end
    end
    apply(1, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 1, 0, 6);
    apply(0, 0, 1, 0, 0, 0, 0);
    checks++;
    if ({addr, ras_empty, ras_full, ras_err} !== expv()) begin
      errors++; $display("FAIL ret_empty got %b want %b", {addr, ras_empty, ras_full, ras_err}, expv());
    end
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 0, i == 1, 5);
    checks++;
    if (ras_err !== (RAS_EN ? 1'b1 : 1'b0)) begin errors++; $display("FAIL err_sticky got %b want %b", ras_err, RAS_EN); end
    apply(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (ras_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", ras_err); end
  endtask

  task automatic test_reset_collision();
    apply(0, 0, 0, 1, 0, 0, 7);
    checks++;
    if (addr !== 4'd7) begin errors++; $display("FAIL call_addr got %0d want 7", addr); end
    apply(0, 0, 0, 1, 0, 0, 10);
    apply(1, 0, 1, 1, 0, 0, 2);
    checks++;
    if ({addr, ras_empty, ras_full, ras_err} !== 7'b0000_100) begin
      errors++; $display("FAIL reset_collision got %b want %b", {addr, ras_empty, ras_full, ras_err}, 7'b0000_100);
    end
    apply(0, 0, 1, 0, 0, 0, 0);
    checks++;
    if ({addr, ras_empty, ras_full, ras_err} !== expv()) begin
      errors++; $display("FAIL ret_after_reset got %b want %b", {addr, ras_empty, ras_full, ras_err}, expv());
    end
  endtask

  task automatic test_random();
    bit r, s, t, c, j, b;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 39) == 0;
      s = $urandom_range(0, 7) == 0;
      t = $urandom_range(0, 3) == 0;
      c = $urandom_range(0, 3) == 0;
      j = $urandom_range(0, 4) == 0;
      b = $urandom_range(0, 3) == 0;
      if (!RAS_EN && t) begin c = 0; j = 0; b = 0; end
      apply(r, s, t, c, j, b, int'($urandom_range(0, 15)));
      checks++;
      if ({addr, ras_empty, ras_full, ras_err} !== expv()) begin
        errors++; $display("FAIL random cycle %0d got %b want %b", i, {addr, ras_empty, ras_full, ras_err}, expv());
      end
    end
  endtask

  initial begin
    {pc_reset, stop, jmp, ban, call, ret} = '0;
    addrJmp = '0;
    m_addr = 0;
    m_err = 0;
    test_reset();
    test_increment();
    test_stall_jump();
    test_branch();
    test_call_ret();
    test_ras_errors();
    test_reset_collision();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
